// File: rtl/fishingrod_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fishingrod_feeder_if : start/data request and byte-serial datapath feed
// Revision 1.0
// ---------------------------------------------------------------------------
interface fishingrod_feeder_if;
  logic        start;
  logic [0:95] pt_in;
  logic [0:63] key_in;
  logic        busy;
  logic [7:0]  inp;
  logic [7:0]  key;
  logic        round0;
  logic [4:0]  round;
  logic [3:0]  step;
  logic        done;

  modport master (
    input  start, pt_in, key_in,
    output busy, inp, key, round0, round, step, done
  );

  modport slave (
    output start, pt_in, key_in,
    input  busy, inp, key, round0, round, step, done
  );
endinterface
`default_nettype wire

// File: rtl/fishingrod_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fishingrod_feeder : byte-serial block/key loader and round sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
module fishingrod_feeder #(
  parameter int NROUNDS = 30,
  parameter int STEPS   = 12
) (
  input  logic                ck,
  input  logic                rstn,
  fishingrod_feeder_if.master bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_load = 2'd1;
  localparam logic [1:0] c_run  = 2'd2;

  localparam logic [3:0] c_last_step  = 4'(STEPS - 1);
  localparam logic [4:0] c_last_round = 5'(NROUNDS);

  logic [1:0]  r_state;
  logic [0:95] r_pt_sr;
  logic [0:63] r_key_sr;

  // Byte 0 goes straight to the outputs at acceptance; the shift registers
  // hold the remaining bytes and back-fill with zeros.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      r_state    <= c_idle;
      r_pt_sr    <= '0;
      r_key_sr   <= '0;
      bus.busy   <= 1'b0;
      bus.inp    <= 8'h00;
      bus.key    <= 8'h00;
      bus.round0 <= 1'b0;
      bus.round  <= 5'd0;
      bus.step   <= 4'd0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_state    <= c_load;
            bus.busy   <= 1'b1;
            bus.round0 <= 1'b1;
            bus.round  <= 5'd0;
            bus.step   <= 4'd0;
            bus.inp    <= bus.pt_in[0:7];
            bus.key    <= bus.key_in[0:7];
            r_pt_sr    <= {bus.pt_in[8:95], 8'h00};
            r_key_sr   <= {bus.key_in[8:63], 8'h00};
          end
        end
        c_load: begin
          if (bus.step == c_last_step) begin
            r_state    <= c_run;
            bus.round0 <= 1'b0;
            bus.round  <= 5'd1;
            bus.step   <= 4'd0;
            bus.inp    <= 8'h00;
            bus.key    <= 8'h00;
          end else begin
            bus.step <= bus.step + 4'd1;
            bus.inp  <= r_pt_sr[0:7];
            bus.key  <= r_key_sr[0:7];
            r_pt_sr  <= {r_pt_sr[8:95], 8'h00};
            r_key_sr <= {r_key_sr[8:63], 8'h00};
          end
        end
        c_run: begin
          if (bus.step == c_last_step) begin
            bus.step <= 4'd0;
            if (bus.round == c_last_round) begin
              r_state   <= c_idle;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              bus.round <= 5'd0;
            end else begin
              bus.round <= bus.round + 5'd1;
            end
          end else begin
            bus.step <= bus.step + 4'd1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fishingrod_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fishingrod_feeder : two instances (NROUNDS=2 and default) against a
// cycle-offset reference model.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_fishingrod_feeder;
  localparam int S = 12;

  logic ck   = 1'b0;
  logic rstn = 1'b0;
  always #5 ck = ~ck;

  fishingrod_feeder_if if_s ();
  fishingrod_feeder_if if_d ();

  fishingrod_feeder #(.NROUNDS(2), .STEPS(S)) u_small (.ck(ck), .rstn(rstn), .bus(if_s));
  fishingrod_feeder #(.NROUNDS(30), .STEPS(S)) u_def  (.ck(ck), .rstn(rstn), .bus(if_d));

  int checks = 0;
  int errors = 0;

  // Model state: k = cycles since the accepting edge (1 = first LOAD cycle)
  int          nr    [2] = '{2, 30};
  int          k     [2];
  bit          valid [2] = '{1'b0, 1'b0};
  logic [0:95] mpt   [2];
  logic [0:63] mkey  [2];

  function automatic bit busy_m(int n, int kk, bit v);
    return v && kk >= 1 && kk <= S * (n + 1);
  endfunction

  function automatic logic [27:0] model_out(int n, int kk, bit v, logic [0:95] p, logic [0:63] kw);
    logic b, d, r0;
    logic [4:0] rd;
    logic [3:0] st;
    logic [7:0] ib, kb;
    int t, u;
    b = 0; d = 0; r0 = 0; rd = 0; st = 0; ib = 0; kb = 0;
    if (v && kk >= 1) begin
      t = kk - 1;
      if (t < S) begin
        b = 1; r0 = 1; st = 4'(t);
        ib = (t < 12) ? p[8*t +: 8] : 8'h00;
        kb = (t < 8) ? kw[8*t +: 8] : 8'h00;
      end else if (t < S * (n + 1)) begin
        b = 1; u = t - S;
        rd = 5'(u / S + 1);
        st = 4'(u % S);
      end else if (t == S * (n + 1)) begin
        d = 1;
      end
    end
    return {b, d, r0, rd, st, ib, kb};
  endfunction

  function automatic logic [27:0] obs_s();
    return {if_s.busy, if_s.done, if_s.round0, if_s.round, if_s.step, if_s.inp, if_s.key};
  endfunction

  function automatic logic [27:0] obs_d();
    return {if_d.busy, if_d.done, if_d.round0, if_d.round, if_d.step, if_d.inp, if_d.key};
  endfunction

  task automatic check_both(input string tag);
    logic [27:0] e, o;
    for (int i = 0; i < 2; i++) begin
      e = model_out(nr[i], k[i], valid[i], mpt[i], mkey[i]);
      o = (i == 0) ? obs_s() : obs_d();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s dut%0d k=%0d observed=%h expected=%h", tag, i, k[i], o, e);
      end
    end
  endtask

  task automatic cyc(input logic st, input logic [0:95] p, input logic [0:63] kw, input string tag);
    bit acc [2];
    for (int i = 0; i < 2; i++) acc[i] = rstn && st && !busy_m(nr[i], k[i], valid[i]);
    if_s.start = st; if_s.pt_in = p; if_s.key_in = kw;
    if_d.start = st; if_d.pt_in = p; if_d.key_in = kw;
    @(posedge ck); #1;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) valid[i] = 1'b0;
      else if (acc[i]) begin valid[i] = 1'b1; k[i] = 1; mpt[i] = p; mkey[i] = kw; end
      else if (valid[i] && k[i] < 100000) k[i]++;
    end
    check_both(tag);
  endtask

  function automatic logic [0:95] rpt();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [0:63] rkey();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int dones, maxr, maxs, done_at;
    k = '{0, 0};
    if_s.start = 0; if_s.pt_in = '0; if_s.key_in = '0;
    if_d.start = 0; if_d.pt_in = '0; if_d.key_in = '0;

    // reset state
    for (int i = 0; i < 3; i++) cyc(1'b1, rpt(), rkey(), "reset");
    rstn = 1'b1;
    cyc(1'b0, rpt(), rkey(), "idle");

    // basic sequence, inputs scrambled every cycle after capture
    cyc(1'b1, 96'h000102030405060708090A0B, 64'hF0F1F2F3F4F5F6F7, "basic_accept");
    for (int i = 0; i < 40; i++) cyc(1'b0, rpt(), rkey(), "basic");

    // start while busy: LOAD step 5 and RUN round 1 step 3
    cyc(1'b1, rpt(), rkey(), "busy_accept");
    for (int i = 2; i < 45; i++) cyc(i == 7 || i == 17, rpt(), rkey(), "start_busy");

    // start held high: restart in every done cycle
    dones = 0;
    for (int i = 1; i <= 111; i++) begin
      cyc(1'b1, rpt(), rkey(), "restart");
      if (if_s.done === 1'b1) dones++;
    end
    checks++;
    assert (dones === 3) else begin
      errors++;
      $error("FAIL restart_done_count observed=%0d expected=3", dones);
    end
    for (int i = 0; i < 40; i++) cyc(1'b0, rpt(), rkey(), "drain");

    // reset mid-operation at RUN round 2 step 6
    cyc(1'b1, rpt(), rkey(), "rst_accept");
    for (int i = 0; i < 30; i++) cyc(1'b0, rpt(), rkey(), "pre_rst");
    #2 rstn = 1'b0;
    #1;
    valid = '{1'b0, 1'b0};
    check_both("async_rst");
    for (int i = 0; i < 3; i++) cyc(1'b1, rpt(), rkey(), "in_rst");
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, rpt(), rkey(), "post_rst");
    cyc(1'b1, rpt(), rkey(), "post_rst_accept");
    for (int i = 0; i < 40; i++) cyc(1'b0, rpt(), rkey(), "post_rst_run");

    // default parameters from a clean reset
    rstn = 1'b0;
    cyc(1'b0, rpt(), rkey(), "def_rst");
    rstn = 1'b1;
    cyc(1'b1, rpt(), rkey(), "def_accept");
    maxr = 0; maxs = 0; done_at = -1;
    for (int i = 2; i <= 380; i++) begin
      cyc(1'b0, rpt(), rkey(), "def_run");
      if (int'(if_d.round) > maxr) maxr = int'(if_d.round);
      if (int'(if_d.step) > maxs) maxs = int'(if_d.step);
      if (if_d.done === 1'b1 && done_at < 0) done_at = i;
    end
    checks++;
    assert (maxr === 30) else begin
      errors++;
      $error("FAIL def_max_round observed=%0d expected=30", maxr);
    end
    checks++;
    assert (maxs === 11) else begin
      errors++;
      $error("FAIL def_max_step observed=%0d expected=11", maxs);
    end
    checks++;
    assert (done_at === 373) else begin
      errors++;
      $error("FAIL def_done_cycle observed=%0d expected=373", done_at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fishingrod_feeder.md
# fishingrod_feeder

Byte-serial loader and round sequencer that drives the input side of the Fishingrod parallel round datapath. It accepts one 96-bit plaintext block and one 64-bit key in a single start cycle, then streams them into the datapath one byte per clock with `round0` asserted. It then counts the round phase, publishing the current round number and byte step, and signals completion. It is the transmitting end of the datapath's byte-serial `inp`/`key`/`round0`/`round` interface.

## Interface
- `NROUNDS`, 30: rounds executed after loading; legal range 1..31.
- `STEPS`, 12: clocks per round and per load phase (bytes in the state); legal range 2..15.
- `ck`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `pt_in`  in  96  plaintext, `[0:95]`; byte j is `pt_in[8j:8j+7]`.
- `key_in`  in  64  key, `[0:63]`; byte j is `key_in[8j:8j+7]`.
- `busy`  out  1  high from the first LOAD cycle through the last RUN cycle.
- `inp`  out  8  plaintext byte to the datapath.
- `key`  out  8  key byte to the datapath.
- `round0`  out  1  high during LOAD only.
- `round`  out  5  current round number (1..NROUNDS) during RUN; 0 otherwise.
- `step`  out  4  byte index within the phase (0..STEPS-1) during LOAD/RUN; 0 otherwise.
- `done`  out  1  one-cycle pulse after the last RUN cycle.

## Operation
- All outputs are registered. Reset value of every output and internal register is 0, and the state is IDLE.
- **IDLE**
  - When `start`=1 at an edge, capture `pt_in` and `key_in` into internal shift registers and go to LOAD with step=0.
- **LOAD** (STEPS cycles; `round0`=1, `busy`=1)
  - At step s, `inp` = plaintext byte s.
  - At step s, `key` = key byte s for s<8, and 0x00 for s≥8.
  - `round`=0.
  - After step STEPS-1, go to RUN with round=1, step=0.
- **RUN** (NROUNDS×STEPS cycles; `busy`=1)
  - `round0`=0, `inp`=0x00, `key`=0x00.
  - `step` counts 0..STEPS-1 and wraps to 0.
  - `round` increments when `step` wraps.
  - After round=NROUNDS, step=STEPS-1, go to IDLE with `done`=1 for exactly one cycle.
- **Start handling**
  - `start` while `busy`=1 is ignored; it is neither queued nor recaptured.
  - `start` in the cycle where `done`=1 is accepted, since the state is already IDLE and `busy`=0.
- **Input stability**
  - `pt_in` and `key_in` are don't-care except at the accepting edge.
  - Changes to them after capture have no effect.
- **Counter widths**
  - Step counter is 4 bits; round counter is 5 bits. Neither overflows within the legal parameter ranges.
  - Terminal compares use the exact parameter values.
- **Reset**
  - `rstn` low at any time forces IDLE and all outputs to 0 immediately (asynchronously).
  - An in-flight operation is abandoned and produces no `done`.
  - After `rstn` rises, the first edge with `start`=1 begins a fresh LOAD.

## Timing
- Counting from `start` accepted at edge E0:
  - LOAD occupies cycles E0+1..E0+STEPS.
  - RUN occupies E0+STEPS+1..E0+STEPS×(NROUNDS+1).
  - `done` is high in cycle E0+STEPS×(NROUNDS+1)+1.
- Total occupancy: STEPS×(NROUNDS+1) busy cycles; default 372.
- Back-to-back throughput: one block per STEPS×(NROUNDS+1)+1 cycles.
- `busy` and `done` are never high in the same cycle.
- `round0` is high for exactly STEPS consecutive cycles per accepted start.
- Zero-latency boundaries:
  - The first `inp` byte appears in the cycle immediately after acceptance.
  - There is no gap between LOAD and RUN.

## Test plan
- **Basic sequence** (NROUNDS=2, STEPS=12). Stimulus: `pt_in`=0x000102030405060708090A0B, `key_in`=0xF0F1F2F3F4F5F6F7, `start` pulsed one cycle.
  - LOAD: `inp` = 00..0B over 12 cycles; `key` = F0..F7 then 00×4; `round0`=1 throughout.
  - RUN: 24 cycles with `round` 1 (steps 0..11) then 2 (steps 0..11).
  - Completion: `done` pulses at cycle 37 after acceptance; `busy` high for 36 cycles.
- **Start while busy.** Pulse `start` with different data at LOAD step 5 and RUN round 1 step 3.
  - Output stream is identical to the undisturbed run; exactly one `done`.
- **Restart on done cycle.** Hold `start`=1 continuously.
  - A new LOAD begins the cycle after each `done`; period is 37 cycles (NROUNDS=2).
- **Reset mid-operation.** Assert `rstn`=0 at RUN round 2 step 6.
  - All outputs read 0 without waiting for a clock edge; no `done` appears.
  - `start` after release produces a full, correct LOAD.
- **Default parameters.** NROUNDS=30, STEPS=12.
  - `round` reaches 30 (5'b11110); `done` appears 373 cycles after acceptance.
  - `step` never exceeds 11.
- **Input capture isolation.** Change `pt_in` and `key_in` every cycle after the accepting edge.
  - `inp` and `key` still reflect the values captured at acceptance.
